// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage: PC increment, default
// widths and reset vector, plus a sizing helper for occupancy counters.
package fetch_pkg;

    localparam int PC_INC  = 4;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = '0;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// Fetch-stage bus: redirect in, instruction-memory port, decode handshake and
// occupancy. The master side is the fetch stage, the slave side its environment.
interface fetch_prefetch_if
    import fetch_pkg::*;
#(
    parameter int N     = PC_W,
    parameter int IW    = INSTR_W,
    parameter int DEPTH = 4
) ();
    localparam int CW = count_width(DEPTH);

    logic          PCSrc_F;
    logic [N-1:0]  PCBranch_F;
    logic [N-1:0]  imem_addr_F;
    logic [IW-1:0] imem_data_F;
    logic          valid_D;
    logic          ready_D;
    logic [IW-1:0] instr_D;
    logic [N-1:0]  pc_D;
    logic [CW-1:0] count_F;

    modport master (
        input  PCSrc_F, PCBranch_F, imem_data_F, ready_D,
        output imem_addr_F, valid_D, instr_D, pc_D, count_F
    );

    modport slave (
        output PCSrc_F, PCBranch_F, imem_data_F, ready_D,
        input  imem_addr_F, valid_D, instr_D, pc_D, count_F
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular queue with a combinational head read; flush empties it in one
// edge, and pointers wrap naturally at the power-of-two depth.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int W     = PC_W + INSTR_W,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = count_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [W-1:0]  entries [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset: contents are only meaningful below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [W-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (push && !flush && (wr_ptr_reg == AW'(gi)))
                    data_reg <= din;
            end
            assign entries[gi] = data_reg;
        end
    endgenerate

    assign dout  = entries[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: owns the PC, prefetches into a small queue while it
// has room, and hands {PC, instruction} pairs to decode; redirects flush it.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int            N        = PC_W,
    parameter int            IW       = INSTR_W,
    parameter int            DEPTH    = 4,
    parameter logic [N-1:0]  RESET_PC = N'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    fetch_prefetch_if.master bus
);

    localparam int CW = count_width(DEPTH);

    logic [N-1:0]    pc_reg, pc_next;
    logic [CW-1:0]   count;
    logic            push, pop;
    logic [N+IW-1:0] head;

    // Push looks only at the registered count so ready_D never reaches the PC.
    assign push = !bus.PCSrc_F && (count < CW'(DEPTH));
    assign pop  = bus.valid_D && bus.ready_D;

    always_comb begin
        pc_next = pc_reg;
        if (bus.PCSrc_F)
            pc_next = {bus.PCBranch_F[N-1:2], 2'b00};
        else if (push)
            pc_next = pc_reg + N'(PC_INC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_reg <= RESET_PC;
        else       pc_reg <= pc_next;
    end

    fetch_fifo #(
        .W     (N + IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.PCSrc_F),
        .din   ({pc_reg, bus.imem_data_F}),
        .dout  (head),
        .count (count)
    );

    assign bus.imem_addr_F     = pc_reg;
    assign bus.valid_D         = (count != '0);
    assign {bus.pc_D, bus.instr_D} = head;
    assign bus.count_F         = count;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: a 64-bit instance for fill, stall,
// redirect and async reset, plus an 8-bit instance for PC wrap-around.
module tb_fetch_prefetch;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cycle;

    fetch_prefetch_if #(.N(64), .IW(32), .DEPTH(4)) bus64 ();
    fetch_prefetch_if #(.N(8),  .IW(32), .DEPTH(4)) bus8 ();

    fetch_prefetch #(.N(64), .IW(32), .DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64)
    );

    fetch_prefetch #(.N(8), .IW(32), .DEPTH(4), .RESET_PC(8'hF8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    // Instruction memory: combinational read, contents = address ^ A5A5A5A5.
    assign bus64.imem_data_F = bus64.imem_addr_F[31:0] ^ 32'hA5A5A5A5;
    assign bus8.imem_data_F  = {24'h0, bus8.imem_addr_F} ^ 32'hA5A5A5A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        $display("cycle %0d addr=%h valid=%b pc_D=%h instr_D=%h count=%0d",
                 cycle, bus64.imem_addr_F, bus64.valid_D, bus64.pc_D,
                 bus64.instr_D, bus64.count_F);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus64.PCSrc_F = 1'b0; bus64.PCBranch_F = '0; bus64.ready_D = 1'b0;
        bus8.PCSrc_F  = 1'b0; bus8.PCBranch_F  = '0; bus8.ready_D  = 1'b1;
        #12;
        checks++;
        if (bus64.imem_addr_F !== 64'h0) begin
            failures++;
            $display("FAIL reset_addr actual=%h required=%h", bus64.imem_addr_F, 64'h0);
        end
        checks++;
        if (bus64.valid_D !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid actual=%b required=0", bus64.valid_D);
        end
        checks++;
        if (bus64.count_F !== 3'd0) begin
            failures++;
            $display("FAIL reset_count actual=%0d required=0", bus64.count_F);
        end
        checks++;
        if (bus8.imem_addr_F !== 8'hF8) begin
            failures++;
            $display("FAIL reset_addr8 actual=%h required=f8", bus8.imem_addr_F);
        end
    endtask

    task automatic test_steady();
        logic [63:0] exp_pc;
        logic [31:0] exp_instr;
        bus64.ready_D = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            exp_pc    = 64'(4 * i);
            exp_instr = 32'(4 * i) ^ 32'hA5A5A5A5;
            checks++;
            if (bus64.valid_D !== 1'b1 || bus64.pc_D !== exp_pc) begin
                failures++;
                $display("FAIL steady_pc[%0d] actual=%b/%h required=1/%h", i, bus64.valid_D, bus64.pc_D, exp_pc);
            end
            checks++;
            if (bus64.instr_D !== exp_instr) begin
                failures++;
                $display("FAIL steady_instr[%0d] actual=%h required=%h", i, bus64.instr_D, exp_instr);
            end
            checks++;
            if (bus64.count_F !== 3'd1) begin
                failures++;
                $display("FAIL steady_count[%0d] actual=%0d required=1", i, bus64.count_F);
            end
        end
    endtask

    task automatic test_stall();
        int          exp_cnt;
        logic [63:0] exp_addr;
        logic [63:0] exp_pc;
        bus64.ready_D = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            exp_cnt  = (i + 1 < 4) ? i + 1 : 4;
            exp_addr = 64'(4 * exp_cnt);
            checks++;
            if (bus64.count_F !== 3'(exp_cnt) || bus64.imem_addr_F !== exp_addr) begin
                failures++;
                $display("FAIL stall_fill[%0d] actual=%0d/%h required=%0d/%h", i, bus64.count_F, bus64.imem_addr_F, exp_cnt, exp_addr);
            end
        end
        checks++;
        if (bus64.pc_D !== 64'h0) begin
            failures++;
            $display("FAIL stall_head actual=%h required=0", bus64.pc_D);
        end
        bus64.ready_D = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_pc = 64'(4 * (i + 1));
            checks++;
            if (bus64.valid_D !== 1'b1 || bus64.pc_D !== exp_pc || bus64.count_F !== 3'd3) begin
                failures++;
                $display("FAIL stall_drain[%0d] actual=%b/%h/%0d required=1/%h/3", i, bus64.valid_D, bus64.pc_D, bus64.count_F, exp_pc);
            end
        end
    endtask

    task automatic test_redirect();
        bus64.ready_D = 1'b0;
        do_reset();
        repeat (3) step();
        bus64.PCSrc_F    = 1'b1;
        bus64.PCBranch_F = 64'hfff0;
        step();
        bus64.PCSrc_F = 1'b0;
        checks++;
        if (bus64.count_F !== 3'd0 || bus64.valid_D !== 1'b0 || bus64.imem_addr_F !== 64'hfff0) begin
            failures++;
            $display("FAIL redirect_flush actual=%0d/%b/%h required=0/0/fff0", bus64.count_F, bus64.valid_D, bus64.imem_addr_F);
        end
        step();
        checks++;
        if (bus64.valid_D !== 1'b1 || bus64.pc_D !== 64'hfff0 || bus64.count_F !== 3'd1) begin
            failures++;
            $display("FAIL redirect_first actual=%b/%h/%0d required=1/fff0/1", bus64.valid_D, bus64.pc_D, bus64.count_F);
        end
        bus64.ready_D = 1'b1;
        step();
        checks++;
        if (bus64.pc_D !== 64'hfff4 || bus64.instr_D !== (32'hfff4 ^ 32'hA5A5A5A5)) begin
            failures++;
            $display("FAIL redirect_second actual=%h/%h required=fff4/%h", bus64.pc_D, bus64.instr_D, 32'hfff4 ^ 32'hA5A5A5A5);
        end
    endtask

    task automatic test_redirect_pop();
        bus64.ready_D = 1'b0;
        do_reset();
        repeat (3) step();
        bus64.ready_D    = 1'b1;
        bus64.PCSrc_F    = 1'b1;
        bus64.PCBranch_F = 64'hfff3;
        #1;
        checks++;
        if (bus64.valid_D !== 1'b1 || bus64.pc_D !== 64'h0) begin
            failures++;
            $display("FAIL redirect_pop_head actual=%b/%h required=1/0", bus64.valid_D, bus64.pc_D);
        end
        step();
        bus64.PCSrc_F = 1'b0;
        checks++;
        if (bus64.count_F !== 3'd0 || bus64.valid_D !== 1'b0 || bus64.imem_addr_F !== 64'hfff0) begin
            failures++;
            $display("FAIL redirect_align actual=%0d/%b/%h required=0/0/fff0", bus64.count_F, bus64.valid_D, bus64.imem_addr_F);
        end
        step();
        checks++;
        if (bus64.valid_D !== 1'b1 || bus64.pc_D !== 64'hfff0 || bus64.count_F !== 3'd1) begin
            failures++;
            $display("FAIL redirect_pop_first actual=%b/%h/%0d required=1/fff0/1", bus64.valid_D, bus64.pc_D, bus64.count_F);
        end
        step();
        checks++;
        if (bus64.valid_D !== 1'b1 || bus64.pc_D !== 64'hfff4) begin
            failures++;
            $display("FAIL redirect_pop_second actual=%b/%h required=1/fff4", bus64.valid_D, bus64.pc_D);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [4];
        exp_pc[0] = 8'hF8; exp_pc[1] = 8'hFC; exp_pc[2] = 8'h00; exp_pc[3] = 8'h04;
        bus8.ready_D = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus8.valid_D !== 1'b1 || bus8.pc_D !== exp_pc[i]) begin
                failures++;
                $display("FAIL wrap_pc[%0d] actual=%b/%h required=1/%h", i, bus8.valid_D, bus8.pc_D, exp_pc[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        bus64.ready_D = 1'b0;
        do_reset();
        repeat (5) step();
        checks++;
        if (bus64.count_F !== 3'd4) begin
            failures++;
            $display("FAIL async_prefill actual=%0d required=4", bus64.count_F);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus64.count_F !== 3'd0 || bus64.valid_D !== 1'b0 || bus64.imem_addr_F !== 64'h0) begin
            failures++;
            $display("FAIL async_reset actual=%0d/%b/%h required=0/0/0", bus64.count_F, bus64.valid_D, bus64.imem_addr_F);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        checks++;
        if (bus64.valid_D !== 1'b1 || bus64.pc_D !== 64'h0 || bus64.count_F !== 3'd1) begin
            failures++;
            $display("FAIL async_restart actual=%b/%h/%0d required=1/0/1", bus64.valid_D, bus64.pc_D, bus64.count_F);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cycle    = 0;
        test_reset();
        test_steady();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
